uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the team's UART transmitter. Uses the same frame: 1 start bit (0), DLEN data bits LSB first, 1 stop bit (1), idle high.
- Samples each bit at its centre using a CLKF/BAUD cycle counter.
- Presents each received word on a single-entry valid/ready output register to the downstream consumer.
- Flags framing errors and overruns.

Parameters:
- BAUD, 9600, serial bit rate in bits/s.
- CLKF, 100000000, clk frequency in Hz. BaudLimit = CLKF/BAUD cycles per bit; HalfLimit = BaudLimit/2. BaudLimit must be at least 4.
- DLEN, 8, data bits per frame (1..16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_rxs  input  1  serial line, asynchronous to clk; idle high.
- o_rvalid  output  1  received word available.
- i_rready  input  1  consumer accepts the word when o_rvalid && i_rready.
- o_rdata  output  DLEN  received word; stable while o_rvalid=1.
- o_ferr  output  1  one-cycle pulse: stop bit sampled 0.
- o_ovr  output  1  one-cycle pulse: new frame completed while o_rvalid=1.
- o_perr  output  1  one-cycle parity-error pulse. Tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset (async assert, sync release) sets the following:
  - o_rvalid=0, o_rdata=0, o_ferr=0, o_ovr=0, o_perr=0.
  - state=RX_IDLE.
  - Both synchronizer flops=1, baud and bit counters=0.
- Reset mid-frame abandons the frame; no outputs are produced for it.
- Input path: i_rxs passes through a 2-flop synchronizer (rxs_s). All FSM decisions use rxs_s.
- The baud counter counts 0..limit-1, restarts on each sample event, and is held at 0 in RX_IDLE.
- FSM states and transitions:
  - RX_IDLE: wait for rxs_s=0 with armed=1. Then clear the counter and go to RX_START. The armed flag sets when rxs_s=1 and clears on entering RX_START, so a held-low (break) line cannot retrigger.
  - RX_START: at count HalfLimit-1, sample rxs_s.
    - If 1: false start; go to RX_IDLE with no outputs.
    - If 0: go to RX_DATA with the bit counter at 0.
  - RX_DATA: every BaudLimit cycles, sample rxs_s into the MSB of a DLEN shift register, shifting right (LSB first). Increment the bit counter. After the DLEN-th sample, go to RX_STOP (or RX_PARITY when enabled).
  - RX_STOP: after BaudLimit cycles, sample rxs_s, then go to RX_IDLE.
    - Sample 1 and o_rvalid=0: on the next cycle, o_rdata<=shift register and o_rvalid<=1.
    - Sample 1 and o_rvalid=1: the new word is dropped, old o_rdata is kept, and o_ovr pulses one cycle.
    - Sample 0: the word is discarded and o_ferr pulses one cycle. Overrun is not also flagged.
  - Illegal state encoding: return to RX_IDLE.
- Latency: from the synchronized start-bit falling edge, o_rvalid rises at (DLEN+1)*BaudLimit + HalfLimit + 1 cycles. Add 2 cycles relative to i_rxs for the synchronizer.
- Handshake:
  - o_rvalid clears on the cycle after o_rvalid && i_rready.
  - If acceptance and a new load occur in the same cycle, the load wins: o_rvalid stays 1 with the new data, and o_ovr is not flagged.
- The receiver never stalls the line; frame reception proceeds regardless of i_rready.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - An RX_PARITY state between RX_DATA and RX_STOP samples one even-parity bit after BaudLimit cycles.
  - Parity is the XOR of the data bits and the parity bit; it must equal 0.
  - On mismatch, o_perr pulses one cycle at the stop-bit sample and the word is discarded.
  - A framing error takes priority over a parity error.
  - Latency grows by BaudLimit.
- When undefined: no parity state, frame as above, o_perr constant 0.

Test Plan (CLKF=160, BAUD=10 → BaudLimit=16, DLEN=8):
- Frame 0xA5, i_rready=1 → o_rdata=0xA5 and o_rvalid high exactly 1 cycle, 155 cycles (144+8+1+2) after the i_rxs falling edge; o_ferr=o_ovr=0.
- i_rxs low for 4 cycles, then high → no o_rvalid; the next valid frame 0x3C is received correctly.
- Frame 0x3C with the stop bit driven 0 → o_ferr pulses 1 cycle, o_rvalid stays 0. Line held low afterwards → no new frame until i_rxs returns high.
- i_rready=0, frames 0x11 then 0x22 → o_rdata stays 0x11 and o_ovr pulses once at the second stop sample. Raise i_rready → o_rvalid drops the next cycle.
- Assert rst during data bit 4 of frame 0xFF, release, then send 0x81 → all outputs 0 during reset, then 0x81 received with no error flags.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 → accepted. Send 0x07 with parity 0 → o_perr pulses, no o_rvalid.

Source files
------------

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 2-flop synchronized input, centre sampling, single-entry
// valid/ready output register. Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int BAUD = 9600,
    parameter int CLKF = 100000000,
    parameter int DLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_rxs,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_ferr,
    output logic            o_ovr,
    output logic            o_perr
);

    localparam int BAUD_LIMIT = CLKF / BAUD;
    localparam int HALF_LIMIT = BAUD_LIMIT / 2;
    localparam int CW         = $clog2(BAUD_LIMIT);
    localparam int BW         = (DLEN > 1) ? $clog2(DLEN) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_LIMIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_LIMIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DLEN - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    rx_state_t       state, nstate;
    logic            rxs_m, rxs_s;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DLEN-1:0] shift;
    logic            armed;
    logic            samp_half, samp_full;
    logic            sample, data_samp, stop_evt;
    logic            par_ok;
    logic            load, ovr_set, ferr_set, perr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxs_m <= 1'b1;
            rxs_s <= 1'b1;
        end else begin
            rxs_m <= i_rxs;
            rxs_s <= rxs_m;
        end
    end

    assign samp_half = (cnt == HALF_LAST);
    assign samp_full = (cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            RX_IDLE:   if (!rxs_s && armed) nstate = RX_START;
            RX_START:  if (samp_half) nstate = rxs_s ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (samp_full && bit_cnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                    nstate = RX_PARITY;
`else
                    nstate = RX_STOP;
`endif
`ifdef UART_RX_PARITY_EN
            RX_PARITY: if (samp_full) nstate = RX_STOP;
`endif
            RX_STOP:   if (samp_full) nstate = RX_IDLE;
            default:   nstate = RX_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = ~(^shift ^ par_bit);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        sample    = 1'b0;
        data_samp = 1'b0;
        stop_evt  = 1'b0;
        load      = 1'b0;
        ovr_set   = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        case (state)
            RX_START:  sample = samp_half;
            RX_DATA: begin
                sample    = samp_full;
                data_samp = samp_full;
            end
            RX_PARITY: sample = samp_full;
            RX_STOP: begin
                sample   = samp_full;
                stop_evt = samp_full;
            end
            default: ;
        endcase
        // Acceptance in the stop-sample cycle frees the register, so the new word loads.
        if (stop_evt) begin
            ferr_set = !rxs_s;
            perr_set = rxs_s && !par_ok;
            load     = rxs_s && par_ok && (!o_rvalid || i_rready);
            ovr_set  = rxs_s && par_ok && o_rvalid && !i_rready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            armed   <= 1'b0;
        end else begin
            cnt <= (state == RX_IDLE || sample) ? '0 : cnt + 1'b1;
            if (state == RX_START)
                bit_cnt <= '0;
            else if (data_samp)
                bit_cnt <= bit_cnt + 1'b1;
            if (data_samp)
                shift <= DLEN'({rxs_s, shift} >> 1);
            // Only re-arm in idle so a line held low after a frame cannot retrigger.
            if (state == RX_IDLE && nstate == RX_START)
                armed <= 1'b0;
            else if (state == RX_IDLE && rxs_s)
                armed <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
            o_perr  <= 1'b0;
        end else begin
            if (state == RX_PARITY && samp_full)
                par_bit <= rxs_s;
            o_perr <= perr_set;
        end
    end
`else
    assign o_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_ferr   <= 1'b0;
            o_ovr    <= 1'b0;
        end else begin
            o_ferr <= ferr_set;
            o_ovr  <= ovr_set;
            if (load) begin
                o_rvalid <= 1'b1;
                o_rdata  <= shift;
            end else if (o_rvalid && i_rready) begin
                o_rvalid <= 1'b0;
            end
        end
    end

endmodule
